// File: rtl/parser_head_loader.sv
// Parser entry stage: loads the first HEAD_WIDTH bits of each packet into an initial layer_info_t and
// forwards every beat through a 1-cycle registered slice. Optional counters via HEAD_LOADER_STATS_EN.
package parser_head_loader_pkg;
    localparam int HEAD_WIDTH        = 512;
    localparam int TAG_WIDTH         = 6;
    localparam int META_WIDTH        = 64;
    localparam int SHIFT_WIDTH       = 8;
    localparam int TYPE_NUM          = 2;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int KEY_FILED_NUM     = 2;
    localparam int KEY_OFFSET_WIDTH  = 8;

    typedef struct packed {
        logic [HEAD_WIDTH+TAG_WIDTH-1:0]                    head;
        logic [META_WIDTH-1:0]                              meta;
        logic [SHIFT_WIDTH-1:0]                             headShift;
        logic [SHIFT_WIDTH-1:0]                             metaShift;
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]         type_offset;
        logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0]       key_offset;
    } layer_info_t;
endpackage

module parser_head_loader
    import parser_head_loader_pkg::*;
#(
    parameter int                   DATA_WIDTH = 128,
    parameter int                   HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH,
    parameter logic [TAG_WIDTH-1:0] TAG_INIT   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_data_valid,
    input  logic                  i_data_last,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_data_ready,
    output logic                  o_pkt_valid,
    output logic                  o_pkt_last,
    output logic [DATA_WIDTH-1:0] o_pkt_data,
    input  logic                  i_pkt_ready,
    output logic                  o_head_valid,
    output layer_info_t           o_layer_info,
    input  logic                  i_conf_wren,
    input  logic                  i_conf_rden,
    input  logic [31:0]           i_conf_addr,
    input  logic [31:0]           i_conf_wdata,
    output logic                  o_conf_rdata_valid,
    output logic [31:0]           o_conf_rdata
);
    localparam int               CNT_W    = (HEAD_BEATS > 1) ? $clog2(HEAD_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HEAD_BEATS - 1);

    typedef enum logic {S_HEAD, S_BODY} state_t;

    state_t                                     state_q, state_d;
    logic [CNT_W-1:0]                           cnt_q, cnt_d;
    logic [HEAD_WIDTH-1:0]                      head_q, head_d;
    logic [TAG_WIDTH-1:0]                       tag_q, tag_d;
    logic                                       head_vld_q, head_vld_d;
    logic                                       pkt_vld_q, pkt_vld_d;
    logic                                       pkt_last_q, pkt_last_d;
    logic [DATA_WIDTH-1:0]                      pkt_dat_q, pkt_dat_d;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_off_q, type_off_d;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] key_off_q, key_off_d;
    logic                                       rd_vld_q, rd_vld_d;
    logic [31:0]                                rd_dat_q, rd_dat_d;

    logic                  data_rdy;
    logic                  beat_acc;
    logic                  head_done;
    logic                  short_done;
    logic [HEAD_WIDTH-1:0] head_base;
    logic                  unused_wdata;

    assign data_rdy     = !pkt_vld_q || i_pkt_ready;
    assign beat_acc     = i_data_valid && data_rdy;
    assign head_done    = beat_acc && (state_q == S_HEAD) && (i_data_last || cnt_q == LAST_CNT);
    assign short_done   = head_done && (cnt_q != LAST_CNT);
    assign unused_wdata = ^i_conf_wdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        head_vld_d = 1'b0;
        tag_d      = tag_q;
        // Beat 0 starts from a cleared buffer so short packets never inherit stale bytes.
        head_base  = (cnt_q == '0) ? '0 : head_q;
        for (int b = 0; b < HEAD_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                head_base[HEAD_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH] = i_data;
            end
        end
        if (head_vld_q) begin
            tag_d = tag_q + TAG_WIDTH'(1);
        end
        if (beat_acc) begin
            case (state_q)
                S_HEAD: begin
                    head_d = head_base;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (head_done) begin
                        head_vld_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = i_data_last ? S_HEAD : S_BODY;
                    end
                end
                default: begin
                    if (i_data_last) begin
                        state_d = S_HEAD;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pkt_vld_d  = pkt_vld_q;
        pkt_last_d = pkt_last_q;
        pkt_dat_d  = pkt_dat_q;
        if (beat_acc) begin
            pkt_vld_d  = 1'b1;
            pkt_last_d = i_data_last;
            pkt_dat_d  = i_data;
        end else if (i_pkt_ready) begin
            pkt_vld_d  = 1'b0;
        end
    end

`ifdef HEAD_LOADER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] short_cnt_q, short_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q + 32'(head_vld_q);
        short_cnt_d = short_cnt_q + 32'(short_done);
        if (i_conf_wren && i_conf_addr == 32'd32) pkt_cnt_d = '0;
        if (i_conf_wren && i_conf_addr == 32'd33) short_cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_q   <= '0;
            short_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end
`else
    logic unused_short;
    assign unused_short = short_done;
`endif

    always_comb begin
        type_off_d = type_off_q;
        key_off_d  = key_off_q;
        rd_vld_d   = i_conf_rden;
        rd_dat_d   = '0;
        for (int t = 0; t < TYPE_NUM; t++) begin
            if (i_conf_wren && i_conf_addr == 32'(t)) type_off_d[t] = i_conf_wdata[TYPE_OFFSET_WIDTH-1:0];
            if (i_conf_rden && i_conf_addr == 32'(t)) rd_dat_d = 32'(type_off_q[t]);
        end
        for (int k = 0; k < KEY_FILED_NUM; k++) begin
            if (i_conf_wren && i_conf_addr == 32'(16 + k)) key_off_d[k] = i_conf_wdata[KEY_OFFSET_WIDTH:0];
            if (i_conf_rden && i_conf_addr == 32'(16 + k)) rd_dat_d = 32'(key_off_q[k]);
        end
`ifdef HEAD_LOADER_STATS_EN
        if (i_conf_rden && i_conf_addr == 32'd32) rd_dat_d = pkt_cnt_q;
        if (i_conf_rden && i_conf_addr == 32'd33) rd_dat_d = short_cnt_q;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_HEAD;
            cnt_q      <= '0;
            head_q     <= '0;
            tag_q      <= TAG_INIT;
            head_vld_q <= 1'b0;
            pkt_vld_q  <= 1'b0;
            pkt_last_q <= 1'b0;
            pkt_dat_q  <= '0;
            type_off_q <= '0;
            key_off_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tag_q      <= tag_d;
            head_vld_q <= head_vld_d;
            pkt_vld_q  <= pkt_vld_d;
            pkt_last_q <= pkt_last_d;
            pkt_dat_q  <= pkt_dat_d;
            type_off_q <= type_off_d;
            key_off_q  <= key_off_d;
            rd_vld_q   <= rd_vld_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    // Offsets are sampled live during the strobe, so a write landing in that same cycle is not yet visible.
    always_comb begin
        o_layer_info = '0;
        if (head_vld_q) begin
            o_layer_info.head        = {head_q, tag_q};
            o_layer_info.type_offset = type_off_q;
            o_layer_info.key_offset  = key_off_q;
        end
    end

    assign o_data_ready       = data_rdy;
    assign o_pkt_valid        = pkt_vld_q;
    assign o_pkt_last         = pkt_last_q;
    assign o_pkt_data         = pkt_dat_q;
    assign o_head_valid       = head_vld_q;
    assign o_conf_rdata_valid = rd_vld_q;
    assign o_conf_rdata       = rd_dat_q;
endmodule
